// File: rtl/bcd_countdown_timer_pkg.sv
// Shared definitions for the MM:SS irrigation countdown timer.
package bcd_countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Largest legal value of a units digit (seconds, minutes, tens of minutes)
    localparam int MAX_UNIT     = 9;
    // Largest legal value of the tens-of-seconds digit
    localparam int MAX_TENS_SEC = 5;

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of the down-counter: saturating load, wrap-to-MAX on borrow.
module bcd_digit_down
    import bcd_countdown_timer_pkg::*;
#(
    parameter int MAX = MAX_UNIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ld,
    input  logic [3:0] ld_val,
    input  logic       dec,
    input  logic       bin,
    output logic [3:0] digit,
    output logic       bout
);

    localparam logic [3:0] MAX_D = 4'(MAX);

    // Out-of-range presets clamp to the digit maximum rather than wrapping.
    function automatic logic [3:0] sat_digit(input logic [3:0] v);
        return (v > MAX_D) ? MAX_D : v;
    endfunction

    // Digit register: load has priority over the borrow-driven decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit <= 4'd0;
        end else if (ld) begin
            digit <= sat_digit(ld_val);
        end else if (dec && bin) begin
            digit <= (digit == 4'd0) ? MAX_D : digit - 4'd1;
        end
    end

    // Borrow propagates upward only when this digit is already zero.
    assign bout = bin && (digit == 4'd0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer: control FSM, one-second prescaler, zero detection.
module bcd_countdown_timer
    import bcd_countdown_timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic       stop,
    input  logic [3:0] pus,
    input  logic [3:0] pds,
    input  logic [3:0] pum,
    input  logic [3:0] pdm,
    output logic [3:0] us,
    output logic [3:0] ds,
    output logic [3:0] um,
    output logic [3:0] dm,
    output logic       active,
    output logic       done
);

    localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

    state_t        state, state_next;
    logic [PW-1:0] presc;
    logic          presc_at_max;
    logic          presc_cnt, presc_clr, tick, ld_en, done_next;
    logic          us_bout, ds_bout, um_bout, cnt_zero;
    logic          last_sec;

    assign presc_at_max = (presc == PRESC_MAX);
    // The next decrement lands on 00:00 exactly when the count reads 00:01.
    assign last_sec = (dm == 4'd0) && (um == 4'd0) && (ds == 4'd0) && (us == 4'd1);

    bcd_digit_down #(.MAX(MAX_UNIT)) u_us (
        .clk(clk), .rst(rst), .ld(ld_en), .ld_val(pus),
        .dec(tick), .bin(1'b1), .digit(us), .bout(us_bout)
    );
    bcd_digit_down #(.MAX(MAX_TENS_SEC)) u_ds (
        .clk(clk), .rst(rst), .ld(ld_en), .ld_val(pds),
        .dec(tick), .bin(us_bout), .digit(ds), .bout(ds_bout)
    );
    bcd_digit_down #(.MAX(MAX_UNIT)) u_um (
        .clk(clk), .rst(rst), .ld(ld_en), .ld_val(pum),
        .dec(tick), .bin(ds_bout), .digit(um), .bout(um_bout)
    );
    // A borrow out of the top digit means every digit is zero.
    bcd_digit_down #(.MAX(MAX_UNIT)) u_dm (
        .clk(clk), .rst(rst), .ld(ld_en), .ld_val(pdm),
        .dec(tick), .bin(um_bout), .digit(dm), .bout(cnt_zero)
    );

    // Next-state and control decode; priority stop > load > start > pause.
    always_comb begin
        state_next = state;
        ld_en      = 1'b0;
        presc_cnt  = 1'b0;
        presc_clr  = 1'b0;
        tick       = 1'b0;
        done_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (stop) begin
                    presc_clr = 1'b1;
                end else if (load) begin
                    ld_en = 1'b1;
                end else if (start) begin
                    if (cnt_zero) begin
                        state_next = ST_DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ST_RUN;
                        presc_clr  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // load is deliberately ignored while the valve is open
                if (stop) begin
                    state_next = ST_IDLE;
                    presc_clr  = 1'b1;
                end else if (pause) begin
                    state_next = ST_PAUSED;
                end else begin
                    presc_cnt = 1'b1;
                    tick      = presc_at_max;
                    if (presc_at_max && last_sec) begin
                        state_next = ST_DONE;
                        done_next  = 1'b1;
                    end
                end
            end
            ST_PAUSED: begin
                if (stop) begin
                    state_next = ST_IDLE;
                    presc_clr  = 1'b1;
                end else if (!pause && start) begin
                    state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                if (stop) begin
                    state_next = ST_IDLE;
                    presc_clr  = 1'b1;
                end else if (load) begin
                    ld_en      = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Registered outputs derived from the upcoming state so they align with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
            done   <= 1'b0;
        end else begin
            active <= (state_next == ST_RUN);
            done   <= done_next;
        end
    end

    // Prescaler: advances only while running, keeps its phase across a pause.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (presc_clr || tick) begin
            presc <= '0;
        end else if (presc_cnt) begin
            presc <= presc + PW'(1);
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed table-driven bench for the BCD countdown timer (TICKS_PER_SEC = 4).
module tb_bcd_countdown_timer;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       load, start, pause, stop;
    logic [3:0] pus, pds, pum, pdm;
    logic [3:0] us, ds, um, dm;
    logic       active, done;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        ld, st, pa, sp;
        logic [15:0] pre;   // {pdm,pum,pds,pus}
        logic [15:0] cnt;   // expected {dm,um,ds,us}
        logic        act, dn;
    } vec_t;

    vec_t vq[$];

    bcd_countdown_timer #(.TICKS_PER_SEC(T)) dut (
        .clk(clk), .rst(rst), .load(load), .start(start), .pause(pause), .stop(stop),
        .pus(pus), .pds(pds), .pum(pum), .pdm(pdm),
        .us(us), .ds(ds), .um(um), .dm(dm), .active(active), .done(done)
    );

    always #5 clk = ~clk;

    task automatic add(input logic ld, input logic st, input logic pa, input logic sp,
                       input logic [15:0] pre, input logic [15:0] cnt,
                       input logic act, input logic dn);
        vec_t v;
        v.ld = ld; v.st = st; v.pa = pa; v.sp = sp;
        v.pre = pre; v.cnt = cnt; v.act = act; v.dn = dn;
        vq.push_back(v);
    endtask

    task automatic idle(input int n, input logic [15:0] cnt, input logic act);
        for (int i = 0; i < n; i++) add(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, cnt, act, 1'b0);
    endtask

    task automatic check(input string nm, input int idx, input logic [15:0] cnt,
                         input logic act, input logic dn);
        logic [15:0] got;
        got = {dm, um, ds, us};
        n_vec++;
        if (got !== cnt || active !== act || done !== dn) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h active=%b done=%b, expected %h active=%b done=%b",
                     nm, idx, got, active, done, cnt, act, dn);
        end
    endtask

    initial begin
        rst = 1'b1; load = 0; start = 0; pause = 0; stop = 0;
        {pdm, pum, pds, pus} = 16'h0000;

        // A: 00:03 full countdown
        add(1,0,0,0, 16'h0003, 16'h0003, 0, 0);
        add(0,1,0,0, 16'h0000, 16'h0003, 1, 0);
        idle(3, 16'h0003, 1);
        idle(4, 16'h0002, 1);
        idle(4, 16'h0001, 1);
        add(0,0,0,0, 16'h0000, 16'h0000, 0, 1);
        idle(1, 16'h0000, 0);
        add(0,1,0,0, 16'h0000, 16'h0000, 0, 0);   // start in DONE: no second pulse
        // B: 01:00 -> 00:59
        add(1,0,0,0, 16'h0100, 16'h0100, 0, 0);
        add(0,1,0,0, 16'h0000, 16'h0100, 1, 0);
        idle(3, 16'h0100, 1);
        idle(1, 16'h0059, 1);
        add(0,0,0,1, 16'h0000, 16'h0059, 0, 0);
        // C: 10:00 -> 09:59
        add(1,0,0,0, 16'h1000, 16'h1000, 0, 0);
        add(0,1,0,0, 16'h0000, 16'h1000, 1, 0);
        idle(3, 16'h1000, 1);
        idle(1, 16'h0959, 1);
        add(0,0,0,1, 16'h0000, 16'h0959, 0, 0);
        // D: preset saturation
        add(1,0,0,0, 16'h008C, 16'h0059, 0, 0);
        add(1,0,0,0, 16'hBFEC, 16'h9959, 0, 0);
        // E: load ignored in RUN, stop at 00:41
        add(1,0,0,0, 16'h0042, 16'h0042, 0, 0);
        add(0,1,0,0, 16'h0000, 16'h0042, 1, 0);
        idle(3, 16'h0042, 1);
        idle(1, 16'h0041, 1);
        add(1,0,0,0, 16'h0033, 16'h0041, 1, 0);
        add(0,0,0,1, 16'h0000, 16'h0041, 0, 0);
        idle(2, 16'h0041, 0);
        // F: start with 00:00
        add(1,0,0,0, 16'h0000, 16'h0000, 0, 0);
        add(0,1,0,0, 16'h0000, 16'h0000, 0, 1);
        idle(1, 16'h0000, 0);
        // G: pause after two prescaler counts keeps the fractional second
        add(1,0,0,0, 16'h0005, 16'h0005, 0, 0);
        add(0,1,0,0, 16'h0000, 16'h0005, 1, 0);
        idle(2, 16'h0005, 1);
        for (int i = 0; i < 10; i++) add(0,0,1,0, 16'h0000, 16'h0005, 0, 0);
        add(0,0,0,0, 16'h0000, 16'h0005, 0, 0);   // pause low, no start: stays paused
        add(0,1,0,0, 16'h0000, 16'h0005, 1, 0);   // resume
        idle(1, 16'h0005, 1);
        idle(1, 16'h0004, 1);
        // H: start+pause together from IDLE
        add(0,0,0,1, 16'h0000, 16'h0004, 0, 0);
        add(0,1,1,0, 16'h0000, 16'h0004, 1, 0);
        add(0,1,1,0, 16'h0000, 16'h0004, 0, 0);
        add(0,0,0,1, 16'h0000, 16'h0004, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check("reset_held", 0, 16'h0000, 1'b0, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_idle", 0, 16'h0000, 1'b0, 1'b0);

        for (int i = 0; i < vq.size(); i++) begin
            load = vq[i].ld; start = vq[i].st; pause = vq[i].pa; stop = vq[i].sp;
            {pdm, pum, pds, pus} = vq[i].pre;
            @(posedge clk); #1;
            check("vec", i, vq[i].cnt, vq[i].act, vq[i].dn);
        end
        load = 0; start = 0; pause = 0; stop = 0;
        {pdm, pum, pds, pus} = 16'h0000;

        // Asynchronous reset in the middle of a countdown
        {pdm, pum, pds, pus} = 16'h0003;
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst", 0, 16'h0002, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("async_rst", 0, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("rst_hold", i, 16'h0000, 1'b0, 1'b0);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("post_rst", i, 16'h0000, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Four-digit BCD MM:SS countdown timer for the irrigation controller. It sits directly downstream of the timer set/clear gating stage and consumes the gated preset digits for units/tens of seconds and minutes. It holds the loaded duration and decrements it once per second while watering. It drives the valve-active flag and a one-cycle done pulse to the sequencing logic.

## Interface
Parameters:
- `TICKS_PER_SEC`, default 50000000: clock cycles per one-second decrement; legal range 2 and up.

Ports:
- `clk` input, 1 bit: single system clock; all state changes on its rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `load` input, 1 bit: capture the preset digits into the counter.
- `start` input, 1 bit: begin or resume counting.
- `pause` input, 1 bit: level; while high, counting is frozen.
- `stop` input, 1 bit: abort to idle; digits are retained.
- `pus`, `pds`, `pum`, `pdm` input, 4 bits each: preset digits for units s, tens s, units min and tens min, in BCD.
- `us`, `ds`, `um`, `dm` output, 4 bits each: current count digits.
- `active` output, 1 bit: high in RUN only; drives the valve.
- `done` output, 1 bit: one-cycle pulse when the count reaches 00:00.

## Operation
- FSM states are IDLE, RUN, PAUSED and DONE.
- Input priority in any state: `stop` > `load` > `start` > `pause`.
- IDLE:
  - `load` captures the digits; the state stays IDLE.
  - `start` with a nonzero count goes to RUN.
  - `start` with 00:00 goes to DONE and pulses `done`.
- RUN:
  - On each tick the count decrements by one second.
  - When the decrement produces 00:00, the state goes to DONE and `done` pulses in the same cycle the digits become 0.
  - `pause` high goes to PAUSED.
  - `load` is ignored.
  - `stop` goes to IDLE.
- PAUSED:
  - The prescaler and digits hold.
  - `pause` low together with `start` returns to RUN.
  - `pause` low without `start` stays PAUSED.
  - `stop` goes to IDLE.
- DONE:
  - Digits hold at 00:00.
  - `load` captures the digits and goes to IDLE.
  - `start` with no load stays DONE and does not pulse again.
- BCD decrement uses a borrow chain:
  - `us`: 0 wraps to 9 and borrows.
  - `ds`: 0 wraps to 5 and borrows.
  - `um`: 0 wraps to 9 and borrows.
  - `dm` decrements; it is never decremented below 0, because zero detection stops the count first.
- Load sanitising: any preset digit above its maximum saturates to that maximum (9 for `us`/`um`/`dm`, 5 for `ds`). Example: `pds`=7 loads 5.
- Maximum duration is 99:59.

## Timing
- Reset values:
  - State is IDLE and all digits are 0.
  - Prescaler is 0.
  - `active` and `done` are 0.
- `load` is registered: the digits show the presets on the cycle after the edge.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 only in RUN.
  - It is cleared on entry to RUN from IDLE and on `stop`.
  - It is not cleared on resume from PAUSED, so fractional seconds are preserved.
- Tick fires when the prescaler equals TICKS_PER_SEC-1. The first decrement occurs exactly TICKS_PER_SEC cycles after the `start` edge.
- `active` is registered; it rises on the cycle after `start` is sampled and falls on the same edge that enters DONE, PAUSED or IDLE.
- `done` is high for exactly one cycle, on the edge entering DONE.
- `start` and `pause` high together in IDLE enter RUN, then go to PAUSED on the next cycle.
- An asynchronous `rst` mid-count forces all outputs to reset values immediately, with no `done` pulse.

## Structure
- A shared package holds:
  - the state encoding constants (`ST_IDLE`=0, `ST_RUN`=1, `ST_PAUSED`=2, `ST_DONE`=3);
  - the digit maxima (`MAX_UNIT`=9, `MAX_TENS_SEC`=5).
- Sub-module `bcd_digit_down`, instantiated four times:
  - parameter MAX;
  - inputs: load enable, load value, decrement enable, borrow-in;
  - outputs: the digit and borrow-out (digit==0 with borrow-in);
  - it performs the saturation on load.
- The top level contains the FSM, the prescaler and zero detection.

## Test plan
- TICKS_PER_SEC=4, load 00:03, start:
  - `active` rises one cycle after start;
  - the digits read 00:02, 00:01 and 00:00 at +4, +8 and +12 cycles;
  - `done` pulses once at +12 and `active` falls at +12.
- Load 01:00, run one tick → digits read 00:59 (borrow through `ds`→5, `us`→9). Load 10:00, one tick → 09:59.
- Load with presets `pus`=12 and `pds`=8 → the digits read 00:59.
- Pause after 2 prescaler counts, hold 10 cycles, release with `start` → the next decrement arrives 2 cycles after resume; the digits are unchanged during the pause.
- `load` during RUN → ignored. `stop` mid-count at 00:41 → IDLE, digits stay 00:41, `active` is 0, no `done` pulse.
- Start with 00:00 loaded → DONE with a `done` pulse and `active` never high. Assert `rst` mid-run → all outputs are 0 immediately, without waiting for a clock edge.
